sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
Drawing engine downstream of the Avalon graphics register interface. Consumes the img_id/imgX/imgY/Start command registers and copies one fixed-size sprite from on-chip sprite ROM into the selected SRAM frame buffer. Skips transparent pixels, clips at screen edges, and reports completion on Done. SRAM writes go through a req/ack port to the SRAM arbiter, which it shares with VGA scan-out.

Parameters:
SPRITE_W, 32, sprite width in pixels
SPRITE_H, 32, sprite height in pixels
NUM_IMG, 8, sprites in ROM
SCREEN_W, 640, visible width
SCREEN_H, 480, visible height
TRANSPARENT_KEY, 16'h0000, ROM colour value that is never written

Ports:
Clk  in  1  clock
RESET  in  1  synchronous active-high reset
img_id  in  3  sprite index
imgX  in  10  screen x of sprite top-left
imgY  in  10  screen y of sprite top-left
back_buf  in  1  target buffer: 0 = FB0 (base 0x00000), 1 = FB1 (base 0x4B000)
Start  in  1  level command from register file
Done  out  1  blit complete; held until Start low
rom_addr  out  ROM_AW  sprite ROM address; ROM_AW = clog2(NUM_IMG*SPRITE_W*SPRITE_H)
rom_data  in  16  ROM pixel, valid 1 cycle after rom_addr (synchronous ROM)
wr_req  out  1  SRAM write request
wr_addr  out  20  SRAM word address
wr_data  out  16  pixel to write
wr_ack  in  1  write accepted this cycle

Behaviour:
- Reset: state IDLE, Done=0, wr_req=0, wr_addr=0, wr_data=0, rom_addr=0, row/col counters 0. Applies mid-blit; the next cycle shows wr_req=0.
- Addressing:
  - rom_addr = img_id*SPRITE_W*SPRITE_H + row*SPRITE_W + col.
  - Pixel address = base + sy*SCREEN_W + sx, where sx = imgX+col and sy = imgY+row.
  - Both sums are 11 bits wide, with no wrap.
- Raster order: col increments fastest, then row.
- IDLE:
  - Start=1 at an edge latches img_id, imgX, imgY, back_buf (plus hflip if enabled) and clears row/col. Next state FETCH.
  - Changes to these inputs after latching are ignored until the next IDLE.
- FETCH: drive rom_addr for the current row/col. Next state WAIT.
- WAIT: rom_data is valid.
  - If rom_data == TRANSPARENT_KEY, or sx >= SCREEN_W, or sy >= SCREEN_H: skip the pixel. Advance, then go to FETCH, or to DONE if this was the last pixel.
  - Otherwise register wr_addr and wr_data and go to WRITE.
- WRITE:
  - wr_req=1, with wr_addr and wr_data held stable.
  - On a cycle where wr_ack=1: deassert wr_req next cycle, advance, then go to FETCH or DONE.
  - wr_ack while not in WRITE is ignored.
- DONE: Done=1. Stay while Start=1. Start=0 goes to IDLE with Done=0 next cycle. If Start was already low, Done pulses for 1 cycle.
- Start falling mid-blit does not abort; the blit completes.
- Timing: a written pixel takes 3 cycles with ack in the first WRITE cycle; a skipped pixel takes 2 cycles. A full opaque 32x32 blit with ack tied high takes 3072 cycles from FETCH entry to DONE entry.
- Last pixel: row = SPRITE_H-1 and col = SPRITE_W-1.

Optional Feature:
BLIT_HFLIP_EN
- Defined: adds input port hflip (1 bit), latched in IDLE with Start. When set, the ROM column read is SPRITE_W-1-col; the screen column stays imgX+col.
- Undefined: no hflip port; behaviour exactly as above.

Decomposition:
- Package blit_pkg holds:
  - blit_state_t enum {IDLE, FETCH, WAIT, WRITE, DONE}
  - FB0_BASE=20'h00000 and FB1_BASE=20'h4B000
  - SCREEN_W/SCREEN_H defaults
- Sub-module blit_addr_gen (combinational): maps base, sx, sy to a 20-bit address using sy*640 = (sy<<9)+(sy<<7), plus the in-bounds flag.

Test Plan:
1. Opaque sprite id0, (0,0), back_buf=0, wr_ack tied 1 -> 1024 writes. First wr_addr 0x00000, last 0x04D9F (31*640+31). Done rises 3072 cycles after FETCH entry.
2. id1 checkerboard with half the pixels 0x0000 -> exactly 512 writes, none with wr_data=0x0000.
3. imgX=620, imgY=470 -> 200 writes, covering cols 620..639 and rows 470..479. No write with x>=640 or y>=480.
4. back_buf=1 at (10,5) -> first wr_addr 0x4BC8A.
5. wr_ack delayed 3 cycles per write -> wr_req, wr_addr, wr_data stable until ack, each pixel written once. Total cycle count grows by 3 per write.
6. RESET at the 100th write, then Start held 1 -> wr_req=0 and Done=0 next cycle. Blit restarts from pixel (0,0). Done then stays 1 until Start cleared and drops the following cycle.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared types and constants for the sprite blitter: FSM state encoding,
// frame-buffer base addresses and default screen geometry.
package blit_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } blit_state_t;

    localparam logic [19:0] FB0_BASE = 20'h00000;
    localparam logic [19:0] FB1_BASE = 20'h4B000;

    localparam int SCREEN_W_DEFAULT = 640;
    localparam int SCREEN_H_DEFAULT = 480;

    function automatic logic [19:0] fb_base(input logic back_buf);
        return back_buf ? FB1_BASE : FB0_BASE;
    endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Combinational screen-to-SRAM address mapper with on-screen check.
// The 640-wide case uses shift-add instead of a multiplier.
module blit_addr_gen
    import blit_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic [19:0] base,
    input  logic [10:0] sx,
    input  logic [10:0] sy,
    output logic [19:0] addr,
    output logic        in_bounds
);

    logic [19:0] sy_ext;
    logic [19:0] row_off;

    assign sy_ext = {9'd0, sy};

    generate
        if (SCREEN_W == 640) begin : g_shift
            assign row_off = (sy_ext << 9) + (sy_ext << 7);
        end else begin : g_mul
            assign row_off = sy_ext * 20'(SCREEN_W);
        end
    endgenerate

    assign addr      = base + row_off + {9'd0, sx};
    assign in_bounds = (sx < 11'(SCREEN_W)) && (sy < 11'(SCREEN_H));

endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from synchronous ROM into an SRAM frame buffer, skipping
// transparent/off-screen pixels. Optional macro BLIT_HFLIP_EN adds hflip.
module sprite_blitter
    import blit_pkg::*;
#(
    parameter int          SPRITE_W        = 32,
    parameter int          SPRITE_H        = 32,
    parameter int          NUM_IMG         = 8,
    parameter int          SCREEN_W        = SCREEN_W_DEFAULT,
    parameter int          SCREEN_H        = SCREEN_H_DEFAULT,
    parameter logic [15:0] TRANSPARENT_KEY = 16'h0000,
    localparam int         ROM_AW          = $clog2(NUM_IMG * SPRITE_W * SPRITE_H)
) (
    input  logic              Clk,
    input  logic              RESET,
    input  logic [2:0]        img_id,
    input  logic [9:0]        imgX,
    input  logic [9:0]        imgY,
    input  logic              back_buf,
`ifdef BLIT_HFLIP_EN
    input  logic              hflip,
`endif
    input  logic              Start,
    output logic              Done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              wr_req,
    output logic [19:0]       wr_addr,
    output logic [15:0]       wr_data,
    input  logic              wr_ack
);

    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);

    blit_state_t state_reg, state_next;

    logic [2:0]       id_reg;
    logic [9:0]       x_reg;
    logic [9:0]       y_reg;
    logic             buf_reg;
    logic [ROW_W-1:0] row_reg;
    logic [COL_W-1:0] col_reg;
    logic [19:0]      wr_addr_reg;
    logic [15:0]      wr_data_reg;
`ifdef BLIT_HFLIP_EN
    logic             hflip_reg;
`endif

    logic [COL_W-1:0] rom_col;
    logic [10:0]      sx;
    logic [10:0]      sy;
    logic [19:0]      pix_addr;
    logic             in_bounds;
    logic             last_pixel;
    logic             skip_pixel;
    logic             advance;

`ifdef BLIT_HFLIP_EN
    assign rom_col = hflip_reg ? (COL_W'(SPRITE_W - 1) - col_reg) : col_reg;
`else
    assign rom_col = col_reg;
`endif

    // Screen column always follows raster order; only the ROM read is mirrored.
    assign rom_addr = ROM_AW'(id_reg) * ROM_AW'(SPRITE_W * SPRITE_H)
                    + ROM_AW'(row_reg) * ROM_AW'(SPRITE_W)
                    + ROM_AW'(rom_col);

    assign sx = {1'b0, x_reg} + 11'(col_reg);
    assign sy = {1'b0, y_reg} + 11'(row_reg);

    blit_addr_gen #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_addr_gen (
        .base      (fb_base(buf_reg)),
        .sx        (sx),
        .sy        (sy),
        .addr      (pix_addr),
        .in_bounds (in_bounds)
    );

    assign last_pixel = (row_reg == ROW_W'(SPRITE_H - 1)) && (col_reg == COL_W'(SPRITE_W - 1));
    assign skip_pixel = (rom_data == TRANSPARENT_KEY) || !in_bounds;
    assign advance    = ((state_reg == WAIT) && skip_pixel) || ((state_reg == WRITE) && wr_ack);

    always_ff @(posedge Clk) begin
        if (RESET) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (Start) state_next = FETCH;
            FETCH:   state_next = WAIT;
            WAIT:    if (skip_pixel) state_next = last_pixel ? DONE : FETCH;
                     else            state_next = WRITE;
            WRITE:   if (wr_ack) state_next = last_pixel ? DONE : FETCH;
            DONE:    if (!Start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_req = (state_reg == WRITE);
        Done   = (state_reg == DONE);
    end

    always_ff @(posedge Clk) begin
        if (RESET) begin
            id_reg      <= '0;
            x_reg       <= '0;
            y_reg       <= '0;
            buf_reg     <= 1'b0;
            row_reg     <= '0;
            col_reg     <= '0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
`ifdef BLIT_HFLIP_EN
            hflip_reg   <= 1'b0;
`endif
        end else begin
            if ((state_reg == IDLE) && Start) begin
                id_reg  <= img_id;
                x_reg   <= imgX;
                y_reg   <= imgY;
                buf_reg <= back_buf;
                row_reg <= '0;
                col_reg <= '0;
`ifdef BLIT_HFLIP_EN
                hflip_reg <= hflip;
`endif
            end else if (advance) begin
                if (col_reg == COL_W'(SPRITE_W - 1)) begin
                    col_reg <= '0;
                    row_reg <= row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
            if ((state_reg == WAIT) && !skip_pixel) begin
                wr_addr_reg <= pix_addr;
                wr_data_reg <= rom_data;
            end
        end
    end

    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter: ROM model, SRAM ack
// responder with write monitor, and one task per scenario.
module tb_sprite_blitter;

    localparam int ROM_AW = 13;

    logic              clk = 1'b0;
    logic              RESET = 1'b1;
    logic [2:0]        img_id = '0;
    logic [9:0]        imgX = '0;
    logic [9:0]        imgY = '0;
    logic              back_buf = 1'b0;
    logic              hflip = 1'b0;
    logic              Start = 1'b0;
    logic              Done;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data = '0;
    logic              wr_req;
    logic [19:0]       wr_addr;
    logic [15:0]       wr_data;
    logic              wr_ack = 1'b1;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    always #5 clk = ~clk;

    sprite_blitter dut (
        .Clk      (clk),
        .RESET    (RESET),
        .img_id   (img_id),
        .imgX     (imgX),
        .imgY     (imgY),
        .back_buf (back_buf),
`ifdef BLIT_HFLIP_EN
        .hflip    (hflip),
`endif
        .Start    (Start),
        .Done     (Done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .wr_req   (wr_req),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack)
    );

    // Sprite ROM: id1 is a checkerboard with transparent odd cells, id2 is
    // tagged 0xAxxx, everything else 0x8xxx; low bits are the pixel index.
    logic [15:0] rom [0:8191];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // SRAM side: ack responder plus write monitor, both at the falling edge.
    bit          ack_tied  = 1'b1;
    int          ack_delay = 0;
    int          wcnt      = 0;
    logic [19:0] cur_base  = '0;
    int          wr_count, zero_cnt, oob_cnt, dup_cnt, stab_err;
    int          min_x, max_x, min_y, max_y;
    logic [19:0] first_addr, last_addr;
    logic [15:0] first_data, last_data;
    bit          hold_pending;
    logic [19:0] hold_addr;
    logic [15:0] hold_data;
    bit          seen [int];

    always @(negedge clk) begin
        int off, px, py;
        if (ack_tied) begin
            wr_ack = 1'b1;
        end else if (wr_req !== 1'b1) begin
            wr_ack = 1'b0;
            wcnt   = 0;
        end else begin
            wr_ack = (wcnt >= ack_delay);
            wcnt++;
        end
        if (hold_pending) begin
            if (wr_req !== 1'b1) stab_err++;
            else if (wr_addr !== hold_addr || wr_data !== hold_data) stab_err++;
        end
        hold_pending = 1'b0;
        if (wr_req === 1'b1 && wr_ack !== 1'b1) begin
            hold_pending = 1'b1;
            hold_addr    = wr_addr;
            hold_data    = wr_data;
        end
        if (wr_req === 1'b1 && wr_ack === 1'b1) begin
            off = int'(wr_addr) - int'(cur_base);
            px  = off % 640;
            py  = off / 640;
            if (wr_count == 0) begin
                first_addr = wr_addr;
                first_data = wr_data;
            end
            last_addr = wr_addr;
            last_data = wr_data;
            if (wr_data == 16'h0000) zero_cnt++;
            if (off < 0 || py >= 480) oob_cnt++;
            if (px < min_x) min_x = px;
            if (px > max_x) max_x = px;
            if (py < min_y) min_y = py;
            if (py > max_y) max_y = py;
            if (seen.exists(int'(wr_addr))) dup_cnt++;
            seen[int'(wr_addr)] = 1'b1;
            wr_count++;
        end
    end

    task automatic clear_stats();
        wr_count = 0; zero_cnt = 0; oob_cnt = 0; dup_cnt = 0; stab_err = 0;
        min_x = 1 << 30; max_x = -1; min_y = 1 << 30; max_y = -1;
        first_addr = '0; last_addr = '0; first_data = '0; last_data = '0;
        hold_pending = 1'b0;
        seen.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int max_cycles, output int cycles);
        cycles = 0;
        while (Done !== 1'b1 && cycles < max_cycles) begin
            tick();
            cycles++;
        end
    endtask

    task automatic start_blit(input logic [2:0] id, input int x, input int y, input logic bb);
        img_id   = id;
        imgX     = 10'(x);
        imgY     = 10'(y);
        back_buf = bb;
        cur_base = bb ? 20'h4B000 : 20'h00000;
        clear_stats();
        Start    = 1'b1;
    endtask

    task automatic finish_blit();
        Start = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        assert_cnt++;
        if (Done !== 1'b0 || wr_req !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_ctrl: Done=%b wr_req=%b, required 0/0", Done, wr_req);
        end
        assert_cnt++;
        if (wr_addr !== 20'h0 || wr_data !== 16'h0 || rom_addr !== '0) begin
            fail_cnt++;
            $display("FAIL reset_data: wr_addr=%h wr_data=%h rom_addr=%h, required 0", wr_addr, wr_data, rom_addr);
        end
        RESET = 1'b0;
        tick();
        $display("reset: Done=%b wr_req=%b wr_addr=%h", Done, wr_req, wr_addr);
    endtask

    task automatic test_opaque();
        int cyc;
        start_blit(3'd0, 0, 0, 1'b0);
        wait_done(20000, cyc);
        assert_cnt++;
        if (cyc - 1 !== 3072) begin
            fail_cnt++;
            $display("FAIL opaque_cycles: FETCH->DONE %0d cycles, required 3072", cyc - 1);
        end
        assert_cnt++;
        if (wr_count !== 1024 || dup_cnt !== 0) begin
            fail_cnt++;
            $display("FAIL opaque_count: writes=%0d dups=%0d, required 1024/0", wr_count, dup_cnt);
        end
        assert_cnt++;
        if (first_addr !== 20'h00000 || last_addr !== 20'h04D9F) begin
            fail_cnt++;
            $display("FAIL opaque_addr: first=%h last=%h, required 00000/04d9f", first_addr, last_addr);
        end
        assert_cnt++;
        if (first_data !== 16'h8000 || last_data !== 16'h83FF) begin
            fail_cnt++;
            $display("FAIL opaque_data: first=%h last=%h, required 8000/83ff", first_data, last_data);
        end
        tick();
        assert_cnt++;
        if (Done !== 1'b1) begin
            fail_cnt++;
            $display("FAIL opaque_done_hold: Done=%b with Start high, required 1", Done);
        end
        Start = 1'b0;
        tick();
        assert_cnt++;
        if (Done !== 1'b0) begin
            fail_cnt++;
            $display("FAIL opaque_done_drop: Done=%b after Start low, required 0", Done);
        end
        tick();
        $display("blit opaque: writes=%0d cycles=%0d first=%h last=%h", wr_count, cyc - 1, first_addr, last_addr);
    endtask

    // Start is only a one-cycle pulse and inputs change after latching.
    task automatic test_transparent();
        int cyc;
        start_blit(3'd1, 100, 100, 1'b0);
        tick();
        Start  = 1'b0;
        imgX   = 10'd300;
        img_id = 3'd5;
        wait_done(20000, cyc);
        assert_cnt++;
        if (cyc !== 2560) begin
            fail_cnt++;
            $display("FAIL checker_cycles: FETCH->DONE %0d cycles, required 2560", cyc);
        end
        assert_cnt++;
        if (wr_count !== 512 || zero_cnt !== 0) begin
            fail_cnt++;
            $display("FAIL checker_count: writes=%0d zero_writes=%0d, required 512/0", wr_count, zero_cnt);
        end
        assert_cnt++;
        if (first_addr !== 20'h0FA64 || last_addr !== 20'h14803) begin
            fail_cnt++;
            $display("FAIL checker_addr: first=%h last=%h, required 0fa64/14803", first_addr, last_addr);
        end
        tick();
        assert_cnt++;
        if (Done !== 1'b0) begin
            fail_cnt++;
            $display("FAIL done_pulse: Done=%b one cycle later with Start low, required 0", Done);
        end
        tick();
        $display("blit checker: writes=%0d zero_writes=%0d cycles=%0d", wr_count, zero_cnt, cyc);
    endtask

    task automatic test_clip();
        int cyc;
        start_blit(3'd0, 620, 470, 1'b0);
        wait_done(20000, cyc);
        assert_cnt++;
        if (wr_count !== 200 || oob_cnt !== 0) begin
            fail_cnt++;
            $display("FAIL clip_count: writes=%0d offscreen=%0d, required 200/0", wr_count, oob_cnt);
        end
        assert_cnt++;
        if (min_x !== 620 || max_x !== 639 || min_y !== 470 || max_y !== 479) begin
            fail_cnt++;
            $display("FAIL clip_range: x=%0d..%0d y=%0d..%0d, required 620..639/470..479", min_x, max_x, min_y, max_y);
        end
        assert_cnt++;
        if (first_addr !== 20'h4996C || last_addr !== 20'h4AFFF) begin
            fail_cnt++;
            $display("FAIL clip_addr: first=%h last=%h, required 4996c/4afff", first_addr, last_addr);
        end
        assert_cnt++;
        if (cyc - 1 !== 2248) begin
            fail_cnt++;
            $display("FAIL clip_cycles: FETCH->DONE %0d cycles, required 2248", cyc - 1);
        end
        finish_blit();
        $display("blit clip: writes=%0d x=%0d..%0d y=%0d..%0d", wr_count, min_x, max_x, min_y, max_y);
    endtask

    task automatic test_back_buf();
        int cyc;
        start_blit(3'd2, 10, 5, 1'b1);
        wait_done(20000, cyc);
        assert_cnt++;
        if (first_addr !== 20'h4BC8A || first_data !== 16'hA000) begin
            fail_cnt++;
            $display("FAIL backbuf_first: addr=%h data=%h, required 4bc8a/a000", first_addr, first_data);
        end
        assert_cnt++;
        if (wr_count !== 1024) begin
            fail_cnt++;
            $display("FAIL backbuf_count: writes=%0d, required 1024", wr_count);
        end
        finish_blit();
        $display("blit back_buf: writes=%0d first=%h", wr_count, first_addr);
    endtask

    task automatic test_slow_ack();
        int cyc;
        ack_tied  = 1'b0;
        ack_delay = 3;
        start_blit(3'd0, 0, 0, 1'b0);
        wait_done(20000, cyc);
        assert_cnt++;
        if (cyc - 1 !== 6144) begin
            fail_cnt++;
            $display("FAIL slow_cycles: FETCH->DONE %0d cycles, required 6144", cyc - 1);
        end
        assert_cnt++;
        if (wr_count !== 1024 || dup_cnt !== 0) begin
            fail_cnt++;
            $display("FAIL slow_count: writes=%0d dups=%0d, required 1024/0", wr_count, dup_cnt);
        end
        assert_cnt++;
        if (stab_err !== 0) begin
            fail_cnt++;
            $display("FAIL slow_stable: %0d unstable request cycles, required 0", stab_err);
        end
        finish_blit();
        ack_tied = 1'b1;
        $display("blit slow_ack: writes=%0d cycles=%0d unstable=%0d", wr_count, cyc - 1, stab_err);
    endtask

    task automatic test_reset_mid_blit();
        int cyc;
        int n;
        start_blit(3'd0, 0, 0, 1'b0);
        n = 0;
        while (!(wr_count == 99 && wr_req === 1'b1) && n < 2000) begin
            tick();
            n++;
        end
        assert_cnt++;
        if (n >= 2000) begin
            fail_cnt++;
            $display("FAIL midreset_reach: writes=%0d after %0d cycles, required 99 then a request", wr_count, n);
        end
        RESET = 1'b1;
        tick();
        assert_cnt++;
        if (wr_req !== 1'b0 || Done !== 1'b0 || rom_addr !== '0) begin
            fail_cnt++;
            $display("FAIL midreset_state: wr_req=%b Done=%b rom_addr=%h, required 0/0/0", wr_req, Done, rom_addr);
        end
        RESET = 1'b0;
        imgX  = 10'd3;
        imgY  = 10'd2;
        clear_stats();
        wait_done(20000, cyc);
        assert_cnt++;
        if (first_addr !== 20'h00503 || first_data !== 16'h8000 || wr_count !== 1024) begin
            fail_cnt++;
            $display("FAIL midreset_restart: first=%h data=%h writes=%0d, required 00503/8000/1024", first_addr, first_data, wr_count);
        end
        assert_cnt++;
        if (cyc - 1 !== 3072) begin
            fail_cnt++;
            $display("FAIL midreset_cycles: FETCH->DONE %0d cycles, required 3072", cyc - 1);
        end
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (Done !== 1'b1) n++;
        end
        assert_cnt++;
        if (n !== 0) begin
            fail_cnt++;
            $display("FAIL midreset_hold: Done low in %0d of 5 cycles with Start high, required 0", n);
        end
        Start = 1'b0;
        tick();
        assert_cnt++;
        if (Done !== 1'b0) begin
            fail_cnt++;
            $display("FAIL midreset_drop: Done=%b after Start low, required 0", Done);
        end
        tick();
        $display("blit reset_restart: writes=%0d first=%h cycles=%0d", wr_count, first_addr, cyc - 1);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin
            int id, idx, r, c;
            id  = i / 1024;
            idx = i % 1024;
            r   = idx / 32;
            c   = idx % 32;
            case (id)
                1:       rom[i] = (((r ^ c) & 1) != 0) ? 16'h0000 : (16'h4000 | 16'(idx));
                2:       rom[i] = 16'hA000 | 16'(idx);
                default: rom[i] = 16'h8000 | 16'(idx);
            endcase
        end
        clear_stats();
        test_reset();
        test_opaque();
        test_transparent();
        test_clip();
        test_back_buf();
        test_slow_ack();
        test_reset_mid_blit();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
